// File: rtl/regfile_wb_arbiter.sv
// Round-robin register-file write-back arbiter: one buffer per requester, trap flush, busy scoreboard.
// Optional same-cycle bypass into an idle arbiter is built when COTM32_WB_BYPASS_EN is defined.
module regfile_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int N_REQ    = 2,
    parameter int N_REGS   = NUM_REGS,
    localparam int AW      = $clog2(N_REGS),
    localparam int PW      = (N_REQ > 2) ? 2 : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ-1:0][AW-1:0]   i_req_addr,
    input  logic [N_REQ-1:0][XLEN-1:0] i_req_data,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic                       i_trap_req,
    output logic                       o_we,
    output logic [AW-1:0]              o_waddr,
    output logic [XLEN-1:0]            o_wdata,
    output logic [N_REGS-1:0]          o_busy
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                     state_q, state_d;
    logic [N_REQ-1:0]           buf_valid_q, buf_valid_d;
    logic [N_REQ-1:0][AW-1:0]   buf_addr_q, buf_addr_d;
    logic [N_REQ-1:0][XLEN-1:0] buf_data_q, buf_data_d;
    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;

    logic             block;
    logic [N_REQ-1:0] cand_buf, grant, bypass, take;
    logic [PW:0]      pick_buf;
`ifdef COTM32_WB_BYPASS_EN
    logic [N_REQ-1:0] cand_byp;
    logic [PW:0]      pick_byp;
`endif

    // Returns {found, index} of the first candidate after ptr, wrapping modulo N_REQ.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] cand, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (cand[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        block    = (state_q == FLUSH) || i_trap_req;
        grant    = '0;
        bypass   = '0;
        o_we     = 1'b0;
        o_waddr  = '0;
        o_wdata  = '0;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) cand_buf[k] = buf_valid_q[k] && (buf_addr_q[k] != '0);
        pick_buf = rr_pick(cand_buf, rr_ptr_q);
`ifdef COTM32_WB_BYPASS_EN
        for (int k = 0; k < N_REQ; k++) cand_byp[k] = i_req_valid[k] && (i_req_addr[k] != '0);
        pick_byp = rr_pick(cand_byp, rr_ptr_q);
`endif
        if (!block && pick_buf[PW]) begin
            grant[pick_buf[PW-1:0]] = 1'b1;
            o_we     = 1'b1;
            o_waddr  = buf_addr_q[pick_buf[PW-1:0]];
            o_wdata  = buf_data_q[pick_buf[PW-1:0]];
            rr_ptr_d = pick_buf[PW-1:0];
        end
`ifdef COTM32_WB_BYPASS_EN
        // Only an entirely empty arbiter forwards a request in its own cycle.
        else if (!block && i_rst && (buf_valid_q == '0) && pick_byp[PW]) begin
            bypass[pick_byp[PW-1:0]] = 1'b1;
            o_we     = 1'b1;
            o_waddr  = i_req_addr[pick_byp[PW-1:0]];
            o_wdata  = i_req_data[pick_byp[PW-1:0]];
            rr_ptr_d = pick_byp[PW-1:0];
        end
`endif

        o_req_ready = (~buf_valid_q | grant) & {N_REQ{~block}};
        take        = i_req_valid & o_req_ready;

        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (block) begin
                buf_valid_d[k] = 1'b0;
            end else if (take[k] && !bypass[k]) begin
                buf_valid_d[k] = 1'b1;
                buf_addr_d[k]  = i_req_addr[k];
                buf_data_d[k]  = i_req_data[k];
            end else if (grant[k] || (buf_valid_q[k] && (buf_addr_q[k] == '0))) begin
                // Writes to register 0 are swallowed after one cycle of occupancy.
                buf_valid_d[k] = 1'b0;
            end
        end

        state_d = RUN;
        if ((state_q == RUN) && i_trap_req) state_d = FLUSH;
    end

    always_comb begin
        o_busy = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (buf_valid_q[k]) o_busy[buf_addr_q[k]] = 1'b1;
        end
        o_busy[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= RUN;
            buf_valid_q <= '0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            rr_ptr_q    <= PW'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule
